// File: rtl/fc_pkg.sv
// Shared constants and state type for the serial CRC-5 frame checker.
// Polynomial x^5+x^4+x^2+1; taps below x^5 listed in CRC_POLY.
package fc_pkg;
  localparam int CRC_W = 5;
  localparam logic [CRC_W-1:0] CRC_POLY = 5'b10101;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    REPORT
  } state_e;
endpackage

// File: rtl/crc5_lfsr.sv
// 5-bit Galois CRC register, one shift per enabled bit.
// Load seeds the register with the first frame bit.
module crc5_lfsr
  import fc_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic             i_bit,
  output logic [CRC_W-1:0] o_nxt
);

  logic [CRC_W-1:0] r_crc;
  logic [CRC_W-1:0] w_step;
  logic [CRC_W-1:0] w_nxt;

  assign w_step = {r_crc[CRC_W-2:0], i_bit}
                ^ (r_crc[CRC_W-1] ? CRC_POLY : '0);

  always_comb begin
    w_nxt = r_crc;
    if (i_load)
      w_nxt = {{(CRC_W-1){1'b0}}, i_bit};
    else if (i_shift)
      w_nxt = w_step;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_crc <= '0;
    else
      r_crc <= w_nxt;
  end

  assign o_nxt = w_nxt;

endmodule

// File: rtl/crc5_frame_chk.sv
// Serial CRC-5 frame checker: FSM, bit counter, result registers.
// Define FCCHK_SYNDROME_EN to expose the final remainder on fcsyn.
module crc5_frame_chk
  import fc_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic             fcclck,
  input  logic             fcnrst,
  input  logic             fcin,
  input  logic             fcvalid,
  input  logic             fcsof,
  output logic             fcbusy,
  output logic             fcdone,
  output logic             fcok,
  output logic             fcovr
`ifdef FCCHK_SYNDROME_EN
  ,
  output logic [CRC_W-1:0] fcsyn
`endif
);

  localparam int FRAME_LEN = DATA_BITS + CRC_W;
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_M1 = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_load;
  logic             w_shift;
  logic             w_last;
  logic             w_ovr;
  logic             r_ok;
  logic             r_ovr;
  logic [CRC_W-1:0] w_crc_nxt;

  crc5_lfsr u_lfsr (
    .i_clk   (fcclck),
    .i_rst_n (fcnrst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_bit   (fcin),
    .o_nxt   (w_crc_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_last      = 1'b0;
    w_ovr       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (fcvalid && fcsof) begin
          w_load      = 1'b1;
          w_cnt_nxt   = ONE;
          w_state_nxt = RECV;
        end
      end
      RECV: begin
        if (fcvalid && fcsof) begin
          w_ovr     = 1'b1;
          w_load    = 1'b1;
          w_cnt_nxt = ONE;
        end else if (fcvalid) begin
          w_shift   = 1'b1;
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == LAST_M1) begin
            w_last      = 1'b1;
            w_state_nxt = REPORT;
          end
        end
      end
      REPORT: begin
        // back-to-back frames: a sof here starts the next frame
        if (fcvalid && fcsof) begin
          w_load      = 1'b1;
          w_cnt_nxt   = ONE;
          w_state_nxt = RECV;
        end else begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge fcclck or negedge fcnrst) begin
    if (!fcnrst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ok    <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovr   <= w_ovr;
      if (w_last)
        r_ok <= (w_crc_nxt == '0);
    end
  end

`ifdef FCCHK_SYNDROME_EN
  logic [CRC_W-1:0] r_syn;

  always_ff @(posedge fcclck or negedge fcnrst) begin
    if (!fcnrst)
      r_syn <= '0;
    else if (w_last)
      r_syn <= w_crc_nxt;
  end

  assign fcsyn = r_syn;
`endif

  assign fcbusy = (r_state == RECV);
  assign fcdone = (r_state == REPORT);
  assign fcok   = r_ok;
  assign fcovr  = r_ovr;

endmodule

// File: tb/tb_crc5_frame_chk.sv
// Directed bench for crc5_frame_chk (DATA_BITS=8), scoreboarded results.
// Build with FCCHK_SYNDROME_EN to also check fcsyn.
module tb_crc5_frame_chk;

  localparam int DB = 8;
  localparam int FL = DB + 5;
  localparam logic [5:0] POLY6 = 6'b110101;

  typedef struct {
    logic       ok;
    logic [4:0] syn;
    int         cyc;
    string      tag;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       fcin;
  logic       fcvalid;
  logic       fcsof;
  logic       fcbusy;
  logic       fcdone;
  logic       fcok;
  logic       fcovr;
  logic [4:0] fcsyn;

  int   tests;
  int   fails;
  int   cyc;
  exp_t q[$];

  crc5_frame_chk #(.DATA_BITS(DB)) dut (
    .fcclck  (clk),
    .fcnrst  (rst_n),
    .fcin    (fcin),
    .fcvalid (fcvalid),
    .fcsof   (fcsof),
    .fcbusy  (fcbusy),
    .fcdone  (fcdone),
    .fcok    (fcok),
    .fcovr   (fcovr)
`ifdef FCCHK_SYNDROME_EN
    ,
    .fcsyn   (fcsyn)
`endif
  );

`ifndef FCCHK_SYNDROME_EN
  assign fcsyn = 5'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // remainder of frame polynomial modulo x^5+x^4+x^2+1 (long division)
  function automatic logic [4:0] crc_rem(input logic [FL-1:0] f);
    logic [FL-1:0] v;
    v = f;
    for (int i = FL - 1; i >= 5; i--)
      if (v[i]) v = v ^ (FL'(POLY6) << (i - 5));
    return v[4:0];
  endfunction

  function automatic logic [FL-1:0] good(input logic [DB-1:0] p);
    logic [FL-1:0] z;
    z = {p, 5'b0};
    return {p, crc_rem(z)};
  endfunction

  always @(negedge clk) begin
    if (rst_n && fcdone) begin
      if (q.size() == 0) begin
        chk("spurious_done", 32'(fcdone), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.tag, "_cyc"}, cyc, e.cyc);
        chk({e.tag, "_ok"}, 32'(fcok), 32'(e.ok));
`ifdef FCCHK_SYNDROME_EN
        chk({e.tag, "_syn"}, 32'(fcsyn), 32'(e.syn));
`endif
      end
    end
  end

  task automatic send_bit(input logic b, input logic s);
    fcin    = b;
    fcsof   = s;
    fcvalid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    fcvalid = 1'b0;
    fcsof   = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input string tag, input logic [FL-1:0] f,
                            input logic exp_ovr, input bit gaps);
    logic [4:0] r;
    for (int i = FL - 1; i >= 0; i--) begin
      if (gaps && i != FL - 1) begin
        for (int g = 0; g < (i % 4); g++) begin
          fcvalid = 1'b0;
          fcsof   = 1'b0;
          @(posedge clk);
          #1;
          chk({tag, "_busy_gap"}, 32'(fcbusy), 32'd1);
        end
      end
      send_bit(f[i], i == FL - 1);
      if (i == FL - 1)
        chk({tag, "_ovr1"}, 32'(fcovr), 32'(exp_ovr));
      if (i == FL - 2)
        chk({tag, "_ovr2"}, 32'(fcovr), 32'd0);
    end
    r = crc_rem(f);
    q.push_back('{ok: (r == 5'd0), syn: r, cyc: cyc, tag: tag});
  endtask

  initial begin
    logic [FL-1:0] fa;
    tests   = 0;
    fails   = 0;
    rst_n   = 1'b0;
    fcin    = 1'b0;
    fcvalid = 1'b0;
    fcsof   = 1'b0;
    #1;
    chk("rst_busy", 32'(fcbusy), 32'd0);
    chk("rst_done", 32'(fcdone), 32'd0);
    chk("rst_ok", 32'(fcok), 32'd0);
    chk("rst_ovr", 32'(fcovr), 32'd0);
    chk("rst_syn", 32'(fcsyn), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // valid bits without sof in IDLE are ignored
    for (int k = 0; k < 3; k++) begin
      send_bit(1'b1, 1'b0);
      chk("idle_ignore", 32'(fcbusy), 32'd0);
    end
    idle(2);

    send_frame("t1_zero", {8'h00, 5'b00000}, 1'b0, 1'b0);
    idle(3);
    send_frame("t2_one", {8'h01, 5'b10101}, 1'b0, 1'b0);
    idle(3);
    chk("t2_ok_hold", 32'(fcok), 32'd1);
    send_frame("t3_bad", {8'h00, 5'b00001}, 1'b0, 1'b0);
    idle(3);
    chk("t3_ok_hold", 32'(fcok), 32'd0);
`ifdef FCCHK_SYNDROME_EN
    chk("t3_syn_hold", 32'(fcsyn), 32'd1);
`endif

    send_frame("t4_gaps", {8'h01, 5'b10101}, 1'b0, 1'b1);
    // non-sof bit in REPORT is ignored
    send_bit(1'b1, 1'b0);
    chk("rep_ignore", 32'(fcbusy), 32'd0);
    idle(3);

    // sof on bit 6 aborts and restarts
    fa = good(8'hA5);
    for (int i = FL - 1; i > FL - 6; i--) send_bit(fa[i], i == FL - 1);
    chk("t5_busy", 32'(fcbusy), 32'd1);
    send_frame("t5_restart", good(8'h3C), 1'b1, 1'b0);
    idle(3);
    chk("t5_ok_hold", 32'(fcok), 32'd1);

    // async reset mid-frame
    fa = good(8'h5A);
    for (int i = FL - 1; i > FL - 5; i--) send_bit(fa[i], i == FL - 1);
    chk("t6_busy_pre", 32'(fcbusy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(fcbusy), 32'd0);
    chk("t6_rst_ok", 32'(fcok), 32'd0);
    chk("t6_rst_ovr", 32'(fcovr), 32'd0);
    chk("t6_rst_done", 32'(fcdone), 32'd0);
    fcvalid = 1'b0;
    fcsof   = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    send_frame("t6_after", {8'h01, 5'b10101}, 1'b0, 1'b0);
    idle(2);

    // back-to-back: second sof arrives in REPORT
    send_frame("b2b_a", {8'hC3, 5'b00110}, 1'b0, 1'b0);
    send_frame("b2b_b", good(8'h96), 1'b0, 1'b0);
    send_frame("b2b_c", good(8'hFF), 1'b0, 1'b0);
    idle(5);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
